vga_pic_window: RTL and testbench
=================================

Name: vga_pic_window

Overview:
Pixel source directly upstream of vga_ctrl. It answers vga_ctrl's pix_data_req / pix_x / pix_y with a 1-cycle-latency pix_data: image-ROM pixels inside a movable window and BG_COLOR outside it. It also owns the window geometry (win_x/win_y/win_w/win_h, wired to vga_ctrl x/y/w/h), moved by a key-toggled bounce state machine that updates only on frame_end.

Parameters:
H_VALID, 640, visible pixels per line
V_VALID, 480, visible lines per frame
IMG_W, 100, image width in pixels
IMG_H, 100, image height in lines
STEP, 2, pixels moved per frame per axis in BOUNCE
BG_COLOR, 16'h0000, RGB565 colour outside window
ADDR_W, 14, ROM address width (>= clog2(IMG_W*IMG_H))

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
sys_rst  in  1  synchronous active-high reset
pix_data_req  in  1  vga_ctrl requests a pixel for (pix_x,pix_y) this cycle
pix_x  in  12  requested column, 0..H_VALID-1
pix_y  in  12  requested line, 0..V_VALID-1
frame_end  in  1  single-cycle pulse after last visible pixel of a frame
key_flag  in  1  single-cycle debounced key pulse; toggles motion mode
rom_addr  out  ADDR_W  image ROM address (synchronous ROM, 1-cycle read)
rom_rd_en  out  1  ROM read enable
rom_data  in  16  ROM data, valid the cycle after rom_rd_en
pix_data  out  16  pixel to vga_ctrl, valid 1 cycle after pix_data_req
win_x, win_y  out  10  window top-left corner
win_w, win_h  out  10  window size; constant IMG_W, IMG_H

Behaviour:
- Reset (sync, sys_rst=1 at posedge): win_x=(H_VALID-IMG_W)/2=270, win_y=(V_VALID-IMG_H)/2=190, dir_x=+ (right), dir_y=+ (down), state=STATIC, addr_cnt=0, in_win_d1=0, so pix_data=BG_COLOR, rom_rd_en=0.
- in_win = pix_data_req && win_x<=pix_x<win_x+IMG_W && win_y<=pix_y<win_y+IMG_H; compare at 12 bits, zero-extended.
- rom_rd_en=in_win (combinational); rom_addr=addr_cnt (registered).
- On in_win: addr_cnt<=addr_cnt+1, wrapping IMG_W*IMG_H-1 -> 0. Row-major scan makes consecutive in-window requests consecutive image pixels; no multiplier.
- frame_end: addr_cnt<=0; takes priority over the increment in the same cycle.
- in_win_d1<=in_win. pix_data = in_win_d1 ? rom_data : BG_COLOR. Latency req->pix_data is exactly 1 cycle.
- Motion FSM states: STATIC, BOUNCE. A key_flag pulse toggles the state. Position changes only on frame_end while the state is BOUNCE, so the window never tears mid-frame.
- Update rule, X axis (Y identical with V_VALID/IMG_H), MAXX=H_VALID-IMG_W:
  - dir + : if win_x+STEP>=MAXX then win_x<=MAXX, dir<=- ; else win_x+=STEP.
  - dir - : if win_x<=STEP then win_x<=0, dir<=+ ; else win_x-=STEP.
- key_flag and frame_end in the same cycle: the move uses the pre-toggle state. STATIC->BOUNCE gives no move this frame; BOUNCE->STATIC gives the final move applied.
- STATIC: position and direction held.
- Reset mid-frame: everything returns to reset values immediately. ROM addressing may misalign until the next frame_end re-zeroes addr_cnt; this is acceptable.
- The window is always fully on-screen, so every frame issues exactly IMG_W*IMG_H in-window requests.

Decomposition:
- Package vga_pic_pkg: H_VALID, V_VALID, RGB565 colour constants, motion state enum {STATIC, BOUNCE}.
- Sub-module win_motion: FSM plus win_x/win_y/direction registers. Inputs frame_end, key_flag; outputs win_x, win_y.
- Top level keeps in_win, addr_cnt and the output mux.

Test Plan:
1. Reset held 3 cycles then released -> win_x=270, win_y=190, win_w=100, win_h=100, pix_data=16'h0000, rom_rd_en=0.
2. STATIC, single-cycle reqs:
   - (269,190) -> next-cycle pix_data=BG_COLOR, no ROM read.
   - (270,190) -> rom_addr=0, next-cycle pix_data=rom_data.
   - (369,190) -> addr 99; (270,191) -> addr 100; (369,289) -> addr 9999.
3. Full 640x480 raster then frame_end -> exactly 10000 rom_rd_en cycles; addr_cnt back to 0; position unchanged.
4. key_flag pulse, then frame_end pulses:
   - win_x goes 272, 274, ...; win_y goes 192, 194, ...
   - From win_x=538: next 540 with dir flips, then 538.
   - win_y clamps at 380 and reverses.
5. key_flag and frame_end in the same cycle, from BOUNCE at (300,220) -> moves to (302,222) and the FSM enters STATIC; a later frame_end leaves (302,222) unchanged.
6. sys_rst asserted mid-frame with addr_cnt=4321, in BOUNCE -> next cycle addr_cnt=0, state STATIC, (270,190); a following raster maps (270,190) to addr 0.

Source files
------------

// File: rtl/vga_pic_pkg.sv
// ---------------------------------------------------------------------------
// vga_pic_pkg
// Shared constants and types for the picture-window pixel source:
//   - default screen / image geometry and motion step
//   - RGB565 colour constants and the default background colour
//   - motion state and direction enums
//   - axis_step(): one-frame bounce update for a single axis
// ---------------------------------------------------------------------------
package vga_pic_pkg;

    localparam int H_VALID = 640;
    localparam int V_VALID = 480;
    localparam int IMG_W   = 100;
    localparam int IMG_H   = 100;
    localparam int STEP    = 2;
    localparam int ADDR_W  = 14;

    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;
    localparam logic [15:0] BG_COLOR  = RGB_BLACK;

    typedef enum logic {
        STATIC,
        BOUNCE
    } motion_state_t;

    typedef enum logic {
        DIR_NEG,
        DIR_POS
    } dir_t;

    typedef struct packed {
        logic [9:0] pos;
        dir_t       dir;
    } axis_t;

    // One bounce step along an axis. The sum is formed at 11 bits so that
    // pos + step can never wrap before the comparison against max_pos.
    // Hitting either edge clamps onto it and reverses direction.
    function automatic axis_t axis_step(input axis_t      cur,
                                        input logic [9:0] max_pos,
                                        input logic [9:0] step);
        axis_t nxt;
        nxt = cur;
        if (cur.dir == DIR_POS) begin
            if (({1'b0, cur.pos} + {1'b0, step}) >= {1'b0, max_pos}) begin
                nxt.pos = max_pos;
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = cur.pos + step;
            end
        end else begin
            if (cur.pos <= step) begin
                nxt.pos = '0;
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = cur.pos - step;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_pic_window_win_motion.sv
// ---------------------------------------------------------------------------
// win_motion
// Owns the window top-left corner and the STATIC/BOUNCE motion FSM.
//   vga_clk   in   pixel clock
//   sys_rst   in   synchronous active-high reset
//   frame_end in   end-of-frame pulse; the only time the window may move
//   key_flag  in   debounced key pulse; toggles STATIC <-> BOUNCE
//   win_x     out  window left column
//   win_y     out  window top line
// ---------------------------------------------------------------------------
module win_motion
    import vga_pic_pkg::*;
#(
    parameter int H_VALID = vga_pic_pkg::H_VALID,
    parameter int V_VALID = vga_pic_pkg::V_VALID,
    parameter int IMG_W   = vga_pic_pkg::IMG_W,
    parameter int IMG_H   = vga_pic_pkg::IMG_H,
    parameter int STEP    = vga_pic_pkg::STEP
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       frame_end,
    input  logic       key_flag,
    output logic [9:0] win_x,
    output logic [9:0] win_y
);

    localparam logic [9:0] MAX_X   = 10'(H_VALID - IMG_W);
    localparam logic [9:0] MAX_Y   = 10'(V_VALID - IMG_H);
    localparam logic [9:0] START_X = 10'((H_VALID - IMG_W) / 2);
    localparam logic [9:0] START_Y = 10'((V_VALID - IMG_H) / 2);
    localparam logic [9:0] STEP_V  = 10'(STEP);

    motion_state_t state_q;
    motion_state_t state_d;
    axis_t         axis_x_q;
    axis_t         axis_x_d;
    axis_t         axis_y_q;
    axis_t         axis_y_d;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q <= STATIC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (key_flag) begin
            state_d = (state_q == STATIC) ? BOUNCE : STATIC;
        end
    end

    // The move is gated by the current (pre-toggle) state, so a key press
    // landing on frame_end never changes what this frame's move does.
    always_comb begin
        axis_x_d = axis_x_q;
        axis_y_d = axis_y_q;
        if (frame_end && (state_q == BOUNCE)) begin
            axis_x_d = axis_step(axis_x_q, MAX_X, STEP_V);
            axis_y_d = axis_step(axis_y_q, MAX_Y, STEP_V);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            axis_x_q <= '{pos: START_X, dir: DIR_POS};
            axis_y_q <= '{pos: START_Y, dir: DIR_POS};
        end else begin
            axis_x_q <= axis_x_d;
            axis_y_q <= axis_y_d;
        end
    end

    assign win_x = axis_x_q.pos;
    assign win_y = axis_y_q.pos;

endmodule

// File: rtl/vga_pic_window.sv
// ---------------------------------------------------------------------------
// vga_pic_window
// Pixel source for vga_ctrl: image-ROM pixels inside a movable window,
// BG_COLOR outside it, returned one cycle after each pix_data_req.
//   vga_clk       in   pixel clock
//   sys_rst       in   synchronous active-high reset
//   pix_data_req  in   pixel request for (pix_x, pix_y)
//   pix_x, pix_y  in   requested column / line (12 bit)
//   frame_end     in   end-of-frame pulse
//   key_flag      in   motion-mode toggle pulse
//   rom_addr      out  image ROM address
//   rom_rd_en     out  image ROM read enable
//   rom_data      in   ROM data, one cycle after rom_rd_en
//   pix_data      out  RGB565 pixel to vga_ctrl
//   win_x, win_y  out  window top-left corner
//   win_w, win_h  out  window size (image size, constant)
// ---------------------------------------------------------------------------
module vga_pic_window
    import vga_pic_pkg::*;
#(
    parameter int          H_VALID  = vga_pic_pkg::H_VALID,
    parameter int          V_VALID  = vga_pic_pkg::V_VALID,
    parameter int          IMG_W    = vga_pic_pkg::IMG_W,
    parameter int          IMG_H    = vga_pic_pkg::IMG_H,
    parameter int          STEP     = vga_pic_pkg::STEP,
    parameter logic [15:0] BG_COLOR = vga_pic_pkg::BG_COLOR,
    parameter int          ADDR_W   = vga_pic_pkg::ADDR_W
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              pix_data_req,
    input  logic [11:0]       pix_x,
    input  logic [11:0]       pix_y,
    input  logic              frame_end,
    input  logic              key_flag,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pix_data,
    output logic [9:0]        win_x,
    output logic [9:0]        win_y,
    output logic [9:0]        win_w,
    output logic [9:0]        win_h
);

    localparam logic [11:0]       IMG_W12   = 12'(IMG_W);
    localparam logic [11:0]       IMG_H12   = 12'(IMG_H);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic              in_win;
    logic              in_win_d1;
    logic [ADDR_W-1:0] addr_cnt;
    logic [11:0]       x_lo;
    logic [11:0]       x_hi;
    logic [11:0]       y_lo;
    logic [11:0]       y_hi;

    win_motion #(
        .H_VALID (H_VALID),
        .V_VALID (V_VALID),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .STEP    (STEP)
    ) u_win_motion (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .frame_end (frame_end),
        .key_flag  (key_flag),
        .win_x     (win_x),
        .win_y     (win_y)
    );

    // Window bounds at 12 bits; the window is always on-screen, so the
    // exclusive upper bound never exceeds H_VALID / V_VALID.
    always_comb begin
        x_lo   = {2'b00, win_x};
        y_lo   = {2'b00, win_y};
        x_hi   = x_lo + IMG_W12;
        y_hi   = y_lo + IMG_H12;
        in_win = pix_data_req
                 && (pix_x >= x_lo) && (pix_x < x_hi)
                 && (pix_y >= y_lo) && (pix_y < y_hi);
    end

    // vga_ctrl scans row-major, so in-window requests arrive in image order
    // and a plain counter replaces a (y*IMG_W + x) multiply. frame_end
    // re-aligns the counter each frame and wins over a same-cycle increment.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            addr_cnt <= '0;
        end else if (frame_end) begin
            addr_cnt <= '0;
        end else if (in_win) begin
            addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        end
    end

    // Tracks which requests went to the ROM so the returning data lines up
    // with the ROM's one-cycle read latency.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            in_win_d1 <= 1'b0;
        end else begin
            in_win_d1 <= in_win;
        end
    end

    assign rom_rd_en = in_win;
    assign rom_addr  = addr_cnt;
    assign pix_data  = in_win_d1 ? rom_data : BG_COLOR;
    assign win_w     = 10'(IMG_W);
    assign win_h     = 10'(IMG_H);

endmodule

// File: tb/tb_vga_pic_window.sv
// ---------------------------------------------------------------------------
// tb_vga_pic_window
// Directed bench for vga_pic_window with a behavioural synchronous ROM whose
// word at address a is 16'h8000 | a.
// ---------------------------------------------------------------------------
module tb_vga_pic_window;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic        pix_data_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_end;
    logic        key_flag;
    logic [13:0] rom_addr;
    logic        rom_rd_en;
    logic [15:0] rom_data;
    logic [15:0] pix_data;
    logic [9:0]  win_x;
    logic [9:0]  win_y;
    logic [9:0]  win_w;
    logic [9:0]  win_h;

    int checks = 0;
    int errors = 0;
    int rdCount;

    vga_pic_window dut (
        .vga_clk      (vga_clk),
        .sys_rst      (sys_rst),
        .pix_data_req (pix_data_req),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_end    (frame_end),
        .key_flag     (key_flag),
        .rom_addr     (rom_addr),
        .rom_rd_en    (rom_rd_en),
        .rom_data     (rom_data),
        .pix_data     (pix_data),
        .win_x        (win_x),
        .win_y        (win_y),
        .win_w        (win_w),
        .win_h        (win_h)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [15:0] romWord(input logic [13:0] a);
        return 16'h8000 | {2'b00, a};
    endfunction

    // Behavioural image ROM with one-cycle read latency.
    initial rom_data = 16'h0000;
    always @(posedge vga_clk) begin
        if (rom_rd_en) rom_data <= romWord(rom_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle for sampling.
    task automatic applyStimulus(input logic req, input int x, input int y,
                                 input logic fe, input logic kf);
        @(negedge vga_clk);
        pix_data_req = req;
        pix_x        = 12'(x);
        pix_y        = 12'(y);
        frame_end    = fe;
        key_flag     = kf;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic frameEnd();
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic checkPos(input string tag, input int ex, input int ey);
        checkOutput({tag, "_x"}, 32'(win_x), 32'(ex));
        checkOutput({tag, "_y"}, 32'(win_y), 32'(ey));
    endtask

    initial begin
        sys_rst      = 1'b1;
        pix_data_req = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        frame_end    = 1'b0;
        key_flag     = 1'b0;

        // Reset and initial geometry
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst = 1'b0;
        #1;
        $display("[TB] reset released");
        checkPos("rst", 270, 190);
        checkOutput("rst_w", 32'(win_w), 100);
        checkOutput("rst_h", 32'(win_h), 100);
        checkOutput("rst_pix", 32'(pix_data), 32'h0000);
        checkOutput("rst_rden", 32'(rom_rd_en), 0);

        // Single requests around the left edge
        applyStimulus(1'b1, 269, 190, 1'b0, 1'b0);
        checkOutput("left_out_rden", 32'(rom_rd_en), 0);
        idle();
        checkOutput("left_out_pix", 32'(pix_data), 32'h0000);
        applyStimulus(1'b1, 270, 190, 1'b0, 1'b0);
        checkOutput("first_rden", 32'(rom_rd_en), 1);
        checkOutput("first_addr", 32'(rom_addr), 0);
        idle();
        checkOutput("first_pix", 32'(pix_data), 32'(romWord(14'd0)));
        checkOutput("addr_inc", 32'(rom_addr), 1);
        frameEnd();
        checkOutput("fe_clear_addr", 32'(rom_addr), 0);
        checkPos("static_fe", 270, 190);

        // In-window row-major scan: edge pixels map to corner addresses
        $display("[TB] window scan");
        for (int y = 190; y < 290; y++) begin
            for (int x = 270; x < 370; x++) begin
                applyStimulus(1'b1, x, y, 1'b0, 1'b0);
                if (x == 369 && y == 190) checkOutput("addr_99", 32'(rom_addr), 99);
                if (x == 270 && y == 191) begin
                    checkOutput("addr_100", 32'(rom_addr), 100);
                    checkOutput("pix_99", 32'(pix_data), 32'(romWord(14'd99)));
                end
                if (x == 369 && y == 289) checkOutput("addr_9999", 32'(rom_addr), 9999);
            end
        end
        idle();
        checkOutput("pix_9999", 32'(pix_data), 32'(romWord(14'd9999)));
        checkOutput("addr_wrap", 32'(rom_addr), 0);

        // Bounding-box raster with a one-pixel margin: exactly one image of reads
        $display("[TB] margin raster");
        frameEnd();
        rdCount = 0;
        for (int y = 189; y <= 290; y++) begin
            for (int x = 269; x <= 370; x++) begin
                applyStimulus(1'b1, x, y, 1'b0, 1'b0);
                if (rom_rd_en === 1'b1) rdCount++;
            end
        end
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("raster_last_pix", 32'(pix_data), 32'h0000);
        idle();
        checkOutput("raster_reads", 32'(rdCount), 10000);
        checkOutput("raster_addr", 32'(rom_addr), 0);
        checkPos("raster_pos", 270, 190);

        // Bounce motion
        $display("[TB] bounce");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
        checkPos("key_only", 270, 190);
        frameEnd();
        checkPos("move1", 272, 192);
        frameEnd();
        checkPos("move2", 274, 194);
        repeat (93) frameEnd();
        checkPos("move95", 460, 380);
        frameEnd();
        checkPos("move96", 462, 378);
        repeat (38) frameEnd();
        checkPos("move134", 538, 302);
        frameEnd();
        checkPos("move135", 540, 300);
        frameEnd();
        checkPos("move136", 538, 298);

        // Key and frame_end in the same cycle
        $display("[TB] key with frame_end");
        @(negedge vga_clk);
        sys_rst = 1'b1;
        @(negedge vga_clk);
        sys_rst = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        repeat (15) frameEnd();
        checkPos("at_300_220", 300, 220);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        idle();
        checkPos("final_move", 302, 222);
        frameEnd();
        checkPos("now_static", 302, 222);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        idle();
        checkPos("start_no_move", 302, 222);
        frameEnd();
        checkPos("bounce_again", 304, 224);

        // Reset in the middle of a frame
        $display("[TB] mid-frame reset");
        for (int n = 0; n < 4321; n++) begin
            applyStimulus(1'b1, 304 + (n % 100), 224 + (n / 100), 1'b0, 1'b0);
        end
        idle();
        checkOutput("addr_4321", 32'(rom_addr), 4321);
        @(negedge vga_clk);
        sys_rst      = 1'b1;
        pix_data_req = 1'b1;
        pix_x        = 12'd325;
        pix_y        = 12'd267;
        @(negedge vga_clk);
        sys_rst      = 1'b0;
        pix_data_req = 1'b0;
        #1;
        checkOutput("mrst_addr", 32'(rom_addr), 0);
        checkOutput("mrst_pix", 32'(pix_data), 32'h0000);
        checkPos("mrst_pos", 270, 190);
        frameEnd();
        checkPos("mrst_static", 270, 190);
        applyStimulus(1'b1, 270, 190, 1'b0, 1'b0);
        checkOutput("mrst_first_addr", 32'(rom_addr), 0);
        checkOutput("mrst_first_rden", 32'(rom_rd_en), 1);
        idle();
        checkOutput("mrst_first_pix", 32'(pix_data), 32'(romWord(14'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
